time_report_arbiter: RTL and testbench

Shares the single UART transmit channel between the stopwatch and the clock time sources. On request, it snapshots the six BCD digits of the granted source and streams a 12-byte ASCII frame ("SW hh:mm:ss\n" or "CL hh:mm:ss\n") into the UART TX over a valid/ready handshake. Simultaneous demand is resolved round-robin. The block sits between the two time-keeping cores and the UART TX.

---
 rtl/time_report_pkg.sv | 33 +++
 rtl/time_report_arbiter_bcd.sv | 24 ++
 rtl/time_report_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_time_report_arbiter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/time_report_pkg.sv
// time_report_pkg
// Shared definitions for the time report arbiter: frame length, the ASCII
// constants used to build a report frame, the arbiter FSM state type and the
// encoding of the two time sources.
package time_report_pkg;

  // Number of bytes in one report frame: "SW hh:mm:ss\n" / "CL hh:mm:ss\n".
  localparam int FRAME_LEN = 12;

  // Fixed punctuation bytes in the frame.
  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_COLON = 8'h3A;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_BAD   = 8'h3F;
  localparam logic [7:0] CH_ZERO  = 8'h30;

  // Source tag letters.
  localparam logic [7:0] CH_S = 8'h53;
  localparam logic [7:0] CH_W = 8'h57;
  localparam logic [7:0] CH_C = 8'h43;
  localparam logic [7:0] CH_L = 8'h4C;

  // Arbiter FSM states.
  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  // Source encoding, also used for src and last_src.
  localparam logic SRC_SW = 1'b0;
  localparam logic SRC_CL = 1'b1;

endpackage

// File: rtl/time_report_arbiter_bcd.sv
// bcd_to_ascii
// Converts one 4-bit BCD digit into its ASCII character. Values that are not
// legal BCD (10..15) are rendered as '?' so a corrupted digit is visible on
// the terminal instead of printing a misleading character.
//
// Ports:
//   bcd_i   in  4  BCD digit
//   ascii_o out 8  ASCII character ('0'..'9' or '?')
module bcd_to_ascii
  import time_report_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [7:0] ascii_o
);

  always_comb begin
    if (bcd_i <= 4'd9) begin
      ascii_o = CH_ZERO | {4'h0, bcd_i};
    end else begin
      ascii_o = CH_BAD;
    end
  end

endmodule

// File: rtl/time_report_arbiter.sv
// time_report_arbiter
// Shares one UART transmit channel between the stopwatch and the clock.
// A request from either source is remembered in a pending flag; when the
// channel is free the arbiter grants one source (round-robin on a tie),
// snapshots its six BCD digits and streams a 12-byte ASCII report frame
// ("SW hh:mm:ss\n" or "CL hh:mm:ss\n") over a valid/ready handshake.
//
// Ports:
//   clk         in   1           system clock
//   rst         in   1           asynchronous, active-high reset
//   req_sw      in   1           stopwatch report request (pulse or level)
//   req_cl      in   1           clock report request (pulse or level)
//   sw_digits   in   24          stopwatch BCD digits {h1,h0,m1,m0,s1,s0}
//   cl_digits   in   24          clock BCD digits, same packing
//   tx_ready    in   1           UART TX can accept a byte
//   tx_valid    out  1           tx_data holds a valid byte
//   tx_data     out  DATA_WIDTH  ASCII byte of the current frame
//   busy        out  1           frame in progress
//   src         out  1           source of the current/last frame (0=SW,1=CL)
//   frame_done  out  1           one-cycle pulse after the last byte is taken
module time_report_arbiter
  import time_report_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FRAME_LEN  = time_report_pkg::FRAME_LEN
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_sw,
  input  logic                  req_cl,
  input  logic [23:0]           sw_digits,
  input  logic [23:0]           cl_digits,
  input  logic                  tx_ready,
  output logic                  tx_valid,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  busy,
  output logic                  src,
  output logic                  frame_done
);

  localparam logic [3:0] LAST_IDX = 4'(FRAME_LEN - 1);

  // Registered state and its next-state companions.
  state_e      state_q, state_d;
  logic        pend_sw_q, pend_sw_d;
  logic        pend_cl_q, pend_cl_d;
  logic        last_src_q, last_src_d;
  logic        src_q, src_d;
  logic [23:0] snap_q, snap_d;
  logic [3:0]  idx_q, idx_d;
  logic        frame_done_q, frame_done_d;

  // Arbitration and byte-building intermediates.
  logic        any_pend;
  logic        grant;
  logic        clr_sw;
  logic        clr_cl;
  logic        accept;
  logic [3:0]  digit;
  logic [7:0]  digit_ascii;
  logic [7:0]  frame_byte;

  // Round-robin grant: a lone pending source wins outright; on a tie the
  // source that did not send the previous frame goes first.
  always_comb begin
    any_pend = pend_sw_q | pend_cl_q;
    if (pend_sw_q && pend_cl_q) begin
      grant = ~last_src_q;
    end else if (pend_cl_q) begin
      grant = SRC_CL;
    end else begin
      grant = SRC_SW;
    end
  end

  assign accept = (state_q == SEND) && tx_ready;

  // Next-state logic. The grant happens only from IDLE, which is where the
  // digits are snapshotted so that live digit changes during a frame cannot
  // tear the report.
  always_comb begin
    state_d      = state_q;
    last_src_d   = last_src_q;
    src_d        = src_q;
    snap_d       = snap_q;
    idx_d        = idx_q;
    frame_done_d = 1'b0;
    clr_sw       = 1'b0;
    clr_cl       = 1'b0;

    case (state_q)
      IDLE: begin
        if (any_pend) begin
          state_d    = SEND;
          src_d      = grant;
          last_src_d = grant;
          snap_d     = (grant == SRC_CL) ? cl_digits : sw_digits;
          idx_d      = 4'd0;
          clr_sw     = (grant == SRC_SW);
          clr_cl     = (grant == SRC_CL);
        end
      end
      SEND: begin
        if (accept) begin
          if (idx_q == LAST_IDX) begin
            state_d      = IDLE;
            frame_done_d = 1'b1;
            idx_d        = 4'd0;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Pending flags: a new request wins over a same-cycle clear, so a request
  // that lands on the grant edge of its own source is not lost. Repeated
  // requests simply merge into the already-set flag.
  always_comb begin
    pend_sw_d = req_sw | (pend_sw_q & ~clr_sw);
    pend_cl_d = req_cl | (pend_cl_q & ~clr_cl);
  end

  // State register. last_src resets to CL so the stopwatch wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      pend_sw_q    <= 1'b0;
      pend_cl_q    <= 1'b0;
      last_src_q   <= SRC_CL;
      src_q        <= SRC_SW;
      snap_q       <= 24'h000000;
      idx_q        <= 4'd0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pend_sw_q    <= pend_sw_d;
      pend_cl_q    <= pend_cl_d;
      last_src_q   <= last_src_d;
      src_q        <= src_d;
      snap_q       <= snap_d;
      idx_q        <= idx_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Pick the snapshot digit addressed by idx so a single converter serves
  // all six digit positions.
  always_comb begin
    digit = 4'h0;
    case (idx_q)
      4'd3:    digit = snap_q[23:20];
      4'd4:    digit = snap_q[19:16];
      4'd6:    digit = snap_q[15:12];
      4'd7:    digit = snap_q[11:8];
      4'd9:    digit = snap_q[7:4];
      4'd10:   digit = snap_q[3:0];
      default: digit = 4'h0;
    endcase
  end

  bcd_to_ascii u_bcd_to_ascii (
    .bcd_i   (digit),
    .ascii_o (digit_ascii)
  );

  // Frame byte for the current index. Everything here depends only on
  // registered state, so the byte stays stable while the sink stalls.
  always_comb begin
    frame_byte = 8'h00;
    case (idx_q)
      4'd0:    frame_byte = (src_q == SRC_CL) ? CH_C : CH_S;
      4'd1:    frame_byte = (src_q == SRC_CL) ? CH_L : CH_W;
      4'd2:    frame_byte = CH_SPACE;
      4'd3,
      4'd4,
      4'd6,
      4'd7,
      4'd9,
      4'd10:   frame_byte = digit_ascii;
      4'd5,
      4'd8:    frame_byte = CH_COLON;
      4'd11:   frame_byte = CH_LF;
      default: frame_byte = 8'h00;
    endcase
  end

  // Outputs are decoded from registered state, so reset clears them at once.
  always_comb begin
    tx_valid   = (state_q == SEND);
    busy       = (state_q == SEND);
    tx_data    = (state_q == SEND) ? DATA_WIDTH'(frame_byte) : '0;
    src        = src_q;
    frame_done = frame_done_q;
  end

endmodule

// File: tb/tb_time_report_arbiter.sv
// tb_time_report_arbiter
// Scoreboard bench for time_report_arbiter. Stimulus pushes the expected
// frame bytes and frame sources into queues; an independent monitor pops and
// compares whenever the DUT offers or hands over a byte or finishes a frame.
module tb_time_report_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_sw;
  logic        req_cl;
  logic [23:0] sw_digits;
  logic [23:0] cl_digits;
  logic        tx_ready;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        busy;
  logic        src;
  logic        frame_done;

  logic [7:0]  expQ[$];
  logic        srcQ[$];
  int          compareCount = 0;
  int          failCount    = 0;
  int          acceptCount  = 0;
  bit          monitorOn    = 1'b0;

  always #5 clk = ~clk;

  time_report_arbiter #(
    .DATA_WIDTH (8),
    .FRAME_LEN  (12)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_sw     (req_sw),
    .req_cl     (req_cl),
    .sw_digits  (sw_digits),
    .cl_digits  (cl_digits),
    .tx_ready   (tx_ready),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .busy       (busy),
    .src        (src),
    .frame_done (frame_done)
  );

  // One comparison: counts it, reports a FAIL line on disagreement.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compareCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
    end
  endtask

  // Queue a hand-written expected frame and its source.
  task automatic pushFrame(input string txt, input logic s);
    for (int i = 0; i < txt.len(); i++) expQ.push_back(txt[i]);
    srcQ.push_back(s);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive request inputs for exactly one sampling edge.
  task automatic applyStimulus(input logic rsw, input logic rcl);
    req_sw = rsw;
    req_cl = rcl;
    @(posedge clk);
    #1;
    req_sw = 1'b0;
    req_cl = 1'b0;
  endtask

  task automatic waitFrameDone(input int budget, output int cycles);
    cycles = 0;
    do begin
      tick(1);
      cycles++;
    end while (!frame_done && cycles < budget);
    checkOutput("frame_done_seen", 32'(frame_done), 32'd1);
  endtask

  task automatic drainFrames(input int budget);
    int n = 0;
    while ((expQ.size() != 0 || srcQ.size() != 0 || busy || frame_done) && n < budget) begin
      tick(1);
      n++;
    end
    checkOutput("drain_done", 32'(expQ.size() == 0 && srcQ.size() == 0), 32'd1);
  endtask

  // Monitor: compares offered bytes against the head of the scoreboard,
  // pops on handshake, and checks the source when a frame completes.
  always @(negedge clk) begin
    if (monitorOn && !rst) begin
      if (tx_valid) begin
        if (expQ.size() == 0) begin
          compareCount++;
          failCount++;
          $display("[TB] FAIL unexpected_byte: got 0x%0h, want no byte", tx_data);
        end else if (tx_ready) begin
          acceptCount++;
          checkOutput("tx_byte", 32'(tx_data), 32'(expQ.pop_front()));
        end else begin
          checkOutput("stall_hold", 32'(tx_data), 32'(expQ[0]));
        end
      end
      if (frame_done) begin
        if (srcQ.size() == 0) begin
          compareCount++;
          failCount++;
          $display("[TB] FAIL unexpected_frame_done: got 1, want 0");
        end else begin
          checkOutput("frame_src", 32'(src), 32'(srcQ.pop_front()));
        end
      end
    end
  end

  initial begin
    int cyc;
    int a0;
    int extra;

    rst       = 1'b1;
    req_sw    = 1'b0;
    req_cl    = 1'b0;
    sw_digits = 24'h000000;
    cl_digits = 24'h000000;
    tx_ready  = 1'b1;

    // Reset values.
    #2;
    checkOutput("rst_tx_valid",   32'(tx_valid),   32'd0);
    checkOutput("rst_tx_data",    32'(tx_data),    32'd0);
    checkOutput("rst_busy",       32'(busy),       32'd0);
    checkOutput("rst_src",        32'(src),        32'd0);
    checkOutput("rst_frame_done", 32'(frame_done), 32'd0);
    tick(3);
    rst = 1'b0;
    monitorOn = 1'b1;
    tick(2);
    checkOutput("idle_no_valid", 32'(tx_valid), 32'd0);

    // Single SW frame with full-rate sink; check latency and frame length.
    $display("[TB] single SW frame");
    sw_digits = 24'h123456;
    cl_digits = 24'h235959;
    pushFrame("SW 12:34:56\n", 1'b0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("lat_k_valid", 32'(tx_valid), 32'd0);
    tick(1);
    checkOutput("lat_k1_valid", 32'(tx_valid), 32'd1);
    checkOutput("busy_send",    32'(busy),     32'd1);
    checkOutput("src_sw",       32'(src),      32'd0);
    waitFrameDone(40, cyc);
    checkOutput("frame_cycles", 32'(cyc), 32'd12);
    checkOutput("busy_after",   32'(busy), 32'd0);
    tick(2);

    // Ties: fresh reset so SW wins first; a second tie raised during the SW
    // frame is then won by CL, followed by the remaining SW request.
    $display("[TB] round-robin ties");
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(1);
    pushFrame("SW 12:34:56\n", 1'b0);
    pushFrame("CL 23:59:59\n", 1'b1);
    pushFrame("SW 12:34:56\n", 1'b0);
    applyStimulus(1'b1, 1'b1);
    tick(3);
    applyStimulus(1'b1, 1'b1);
    drainFrames(200);
    tick(3);
    checkOutput("idle_after_ties", 32'(tx_valid), 32'd0);

    // Random back-pressure during a frame.
    $display("[TB] random tx_ready");
    sw_digits = 24'h070809;
    pushFrame("SW 07:08:09\n", 1'b0);
    a0 = acceptCount;
    applyStimulus(1'b1, 1'b0);
    cyc = 0;
    while ((expQ.size() != 0 || srcQ.size() != 0) && cyc < 400) begin
      tx_ready = 1'($urandom_range(0, 1));
      tick(1);
      cyc++;
    end
    tx_ready = 1'b1;
    checkOutput("random_done",  32'(srcQ.size()), 32'd0);
    checkOutput("accept_count", 32'(acceptCount - a0), 32'd12);
    tick(2);

    // Snapshot: a bad digit at request time, live digits changed mid-frame.
    $display("[TB] snapshot and bad digit");
    sw_digits = 24'h1A3456;
    pushFrame("SW 1?:34:56\n", 1'b0);
    applyStimulus(1'b1, 1'b0);
    tick(1);
    sw_digits = 24'h999999;
    tick(3);
    sw_digits = 24'h000000;
    drainFrames(100);
    tick(2);

    // Three CL pulses during an SW frame merge into one CL frame.
    $display("[TB] merged CL requests");
    sw_digits = 24'h123456;
    pushFrame("SW 12:34:56\n", 1'b0);
    pushFrame("CL 23:59:59\n", 1'b1);
    applyStimulus(1'b1, 1'b0);
    tick(1);
    applyStimulus(1'b0, 1'b1);
    tick(2);
    applyStimulus(1'b0, 1'b1);
    tick(1);
    applyStimulus(1'b0, 1'b1);
    drainFrames(200);
    extra = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (tx_valid) extra++;
    end
    checkOutput("no_extra_frame", 32'(extra), 32'd0);

    // Reset mid-frame at idx 5 with a CL request pending.
    $display("[TB] reset mid-frame");
    pushFrame("SW 12:34:56\n", 1'b0);
    applyStimulus(1'b1, 1'b1);
    tick(6);
    checkOutput("idx5_byte", 32'(tx_data), 32'h3A);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midrst_tx_valid",   32'(tx_valid),   32'd0);
    checkOutput("midrst_tx_data",    32'(tx_data),    32'd0);
    checkOutput("midrst_busy",       32'(busy),       32'd0);
    checkOutput("midrst_frame_done", 32'(frame_done), 32'd0);
    expQ.delete();
    srcQ.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    extra = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (tx_valid) extra++;
    end
    checkOutput("lost_requests", 32'(extra), 32'd0);

    checkOutput("queue_empty", 32'(expQ.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

  // Global time bound so a stuck handshake still ends the run.
  initial begin
    #200000;
    failCount++;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
